fp_norm_round: RTL and testbench



---
 rtl/fpm_pkg.sv | 31 +++
 rtl/fp_round_rne.sv | 29 ++
 rtl/fp_norm_round.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_norm_round.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared definitions for the FP multiplier back end (normalise / round / pack).
// Contents:
//   - binary32 constants (bias, max biased exponent, canonical quiet NaN)
//   - bit positions inside the 4-bit flags vector {invalid, overflow, underflow, inexact}
//   - stage-1 record carried from the normaliser to the rounder
package fpm_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int FRAC_W  = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Stage-1 record. The exponent and tag fields follow the top-level EXP_W/TAG_W
    // parameters, so the top registers them next to this record.
    typedef struct packed {
        logic              sign;
        logic [FRAC_W-1:0] frac;
        logic              g;
        logic              st;
        logic              nan;
        logic              inf;
        logic              zero;
    } s1_rec_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a 23-bit fraction with guard/sticky.
// Ports:
//   i_frac    : fraction bits below the hidden 1
//   i_g, i_st : guard bit and sticky OR of everything below it
//   o_m       : {1, frac} + round-up increment (25 bits)
//   o_carry   : rounding carried out of the significand (o_m[24])
//   o_inexact : any discarded bit was non-zero
module fp_round_rne
    import fpm_pkg::*;
(
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_g,
    input  logic              i_st,
    output logic [FRAC_W+1:0] o_m,
    output logic              o_carry,
    output logic              o_inexact
);

    logic w_up;

    always_comb begin
        // Ties (g=1, st=0) round up only when the LSB is odd.
        w_up      = i_g & (i_st | i_frac[0]);
        o_m       = {2'b01, i_frac} + {{(FRAC_W + 1){1'b0}}, w_up};
        o_carry   = o_m[FRAC_W+1];
        o_inexact = i_g | i_st;
    end

endmodule

// File: rtl/fp_norm_round.sv
// FP multiplier back end: normalises the 48-bit mantissa product, rounds to
// nearest-even, resolves overflow/underflow/special operands and packs binary32.
// Two register stages with valid/ready on both sides (1/cycle, 2-cycle latency).
// Build option: define FPM_DENORM_EN for gradual underflow (denormal results);
// otherwise tiny results flush to signed zero.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake
//   prod                 : 2.46 fixed-point product in [1,4)
//   sign, exp_sum        : result sign, ea+eb-127 (signed, EXP_W bits)
//   in_nan/in_inf/in_zero: special-operand flags
//   in_tag / out_tag     : sideband tag carried through
//   out_valid / out_ready: downstream handshake
//   result, flags        : packed binary32, {invalid, overflow, underflow, inexact}
module fp_norm_round
    import fpm_pkg::*;
#(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [47:0]        prod,
    input  logic               sign,
    input  logic [EXP_W-1:0]   exp_sum,
    input  logic               in_nan,
    input  logic               in_inf,
    input  logic               in_zero,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result,
    output logic [3:0]         flags,
    output logic [TAG_W-1:0]   out_tag
);

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic w_en1, w_en2;
    logic r_v1, r_v2;

    always_comb begin
        w_en2    = !r_v2 | out_ready;
        w_en1    = !r_v1 | w_en2;
        in_ready = w_en1;
    end

    // ---------------------------------------------------------------------
    // Stage 1: normalise
    // ---------------------------------------------------------------------
    s1_rec_t                w_s1_d;
    logic signed [EXP_W:0]  w_e_d;
    s1_rec_t                r_s1;
    logic signed [EXP_W:0]  r_s1_e;
    logic [TAG_W-1:0]       r_s1_tag;

    always_comb begin
        w_s1_d      = '0;
        w_s1_d.sign = sign;
        w_s1_d.nan  = in_nan;
        w_s1_d.inf  = in_inf;
        w_s1_d.zero = in_zero;
        if (prod[47]) begin
            w_s1_d.frac = prod[46:24];
            w_s1_d.g    = prod[23];
            w_s1_d.st   = |prod[22:0];
        end else begin
            w_s1_d.frac = prod[45:23];
            w_s1_d.g    = prod[22];
            w_s1_d.st   = |prod[21:0];
        end
        // Sign-extend one bit so exp_sum+1 cannot wrap.
        w_e_d = {exp_sum[EXP_W-1], exp_sum} + {{EXP_W{1'b0}}, prod[47]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_s1     <= '0;
            r_s1_e   <= '0;
            r_s1_tag <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1     <= w_s1_d;
                r_s1_e   <= w_e_d;
                r_s1_tag <= in_tag;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: round and pack
    // ---------------------------------------------------------------------
    logic [FRAC_W+1:0]       w_m;
    logic                    w_carry;
    logic                    w_inexact;
    logic signed [EXP_W+1:0] w_e_rnd;
    logic [31:0]             w_res;
    logic [3:0]              w_flags;

    fp_round_rne u_round (
        .i_frac    (r_s1.frac),
        .i_g       (r_s1.g),
        .i_st      (r_s1.st),
        .o_m       (w_m),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    always_comb begin
        w_e_rnd = {r_s1_e[EXP_W], r_s1_e} + {{(EXP_W + 1){1'b0}}, w_carry};
    end

`ifdef FPM_DENORM_EN
    localparam logic signed [EXP_W+1:0] E_ONE = 1;

    logic signed [EXP_W+1:0] w_sh_full;
    logic [4:0]              w_sh;
    logic [49:0]             w_dn_vec;
    logic [FRAC_W-1:0]       w_dn_frac;
    logic                    w_dn_g;
    logic                    w_dn_st;
    logic [FRAC_W+1:0]       w_dn_m;
    logic                    w_dn_carry;
    logic                    w_dn_inexact;
    logic                    w_unused_dn;

    always_comb begin
        w_sh_full = E_ONE - {r_s1_e[EXP_W], r_s1_e};
        if (r_s1_e > 0) begin
            w_sh = 5'd0;
        end else if (w_sh_full > 26) begin
            w_sh = 5'd26;
        end else begin
            w_sh = w_sh_full[4:0];
        end
        // {hidden, frac, g} shifted right with 26 zero bits below to catch the
        // shifted-out bits; the hidden position is always 0 after a shift >= 1.
        w_dn_vec  = 50'({1'b1, r_s1.frac, r_s1.g, 26'b0} >> w_sh);
        w_dn_frac = w_dn_vec[49:27];
        w_dn_g    = w_dn_vec[26];
        w_dn_st   = r_s1.st | (|w_dn_vec[25:0]);
    end

    fp_round_rne u_round_dn (
        .i_frac    (w_dn_frac),
        .i_g       (w_dn_g),
        .i_st      (w_dn_st),
        .o_m       (w_dn_m),
        .o_carry   (w_dn_carry),
        .o_inexact (w_dn_inexact)
    );

    // The rounder's hidden-bit position carries no information for a denormal.
    assign w_unused_dn = w_dn_m[FRAC_W];
`endif

    // Normal path: the hidden bit of m is implicit; after a carry m[22:0] is 0.
    logic w_unused;
    assign w_unused = w_m[FRAC_W];

    always_comb begin
        w_res                 = {r_s1.sign, w_e_rnd[7:0], w_m[FRAC_W-1:0]};
        w_flags               = '0;
        w_flags[FLAG_INEXACT] = w_inexact;

        if (w_e_rnd >= EXP_MAX) begin
            w_res                   = {r_s1.sign, 8'hFF, 23'b0};
            w_flags[FLAG_OVERFLOW]  = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
`ifdef FPM_DENORM_EN
        end else if (r_s1_e <= 0) begin
            // Rounding up out of the largest denormal lands on exponent field 1.
            w_res                   = {r_s1.sign, 7'b0, w_dn_carry, w_dn_m[FRAC_W-1:0]};
            w_flags[FLAG_UNDERFLOW] = w_dn_inexact;
            w_flags[FLAG_INEXACT]   = w_dn_inexact;
`else
        end else if (w_e_rnd <= 0) begin
            w_res                   = {r_s1.sign, 31'b0};
            w_flags[FLAG_UNDERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
`endif
        end

        // Special operands override everything computed above.
        if (r_s1.nan || (r_s1.inf && r_s1.zero)) begin
            w_res                 = QNAN;
            w_flags               = '0;
            w_flags[FLAG_INVALID] = !r_s1.nan & r_s1.inf & r_s1.zero;
        end else if (r_s1.inf) begin
            w_res   = {r_s1.sign, 8'hFF, 23'b0};
            w_flags = '0;
        end else if (r_s1.zero) begin
            w_res   = {r_s1.sign, 31'b0};
            w_flags = '0;
        end
    end

    // Output registers only load on a transfer into stage 2, so they hold
    // steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            result  <= '0;
            flags   <= '0;
            out_tag <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                result  <= w_res;
                flags   <= w_flags;
                out_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_v2;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, latency, backpressure
// ordering and mid-flight reset, with a queue scoreboard of expected results.
module tb_fp_norm_round;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_OVF  = 4'b0100;
    localparam logic [3:0] F_UNF  = 4'b0010;
    localparam logic [3:0] F_INX  = 4'b0001;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] prod;
    logic        sign;
    logic [9:0]  exp_sum;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {result, flags, tag}
    logic [39:0] exp_q[$];

    fp_norm_round #(
        .EXP_W (10),
        .TAG_W (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign      (sign),
        .exp_sum   (exp_sum),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL out_unexpected: got tag %0h result %0h, expected no output",
                           out_tag, result);
                end
            end else begin
                check("out", 64'({result, flags, out_tag}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [47:0] p, input logic s, input logic [9:0] e,
                         input logic nan, input logic inf, input logic zero,
                         input logic [3:0] tag);
        prod     = p;
        sign     = s;
        exp_sum  = e;
        in_nan   = nan;
        in_inf   = inf;
        in_zero  = zero;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Offer one operand set, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [47:0] p, input logic s, input logic [9:0] e,
                        input logic nan, input logic inf, input logic zero,
                        input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef);
        logic ok = 1'b0;
        drive(p, s, e, nan, inf, zero, tag);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
        exp_q.push_back({er, ef, tag});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    logic [31:0] unf_res;
    logic [3:0]  unf_flags;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(48'h0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        in_valid  = 1'b0;
`ifdef FPM_DENORM_EN
        unf_res   = 32'h0040_0000;
        unf_flags = F_NONE;
`else
        unf_res   = 32'h0000_0000;
        unf_flags = F_UNF | F_INX;
`endif

        // Reset state
        #8;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        #4;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // 1.0 x 1.0 with latency check: visible after the second edge
        send(48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h1, 32'h3F80_0000, F_NONE);
        @(negedge clk);
        check("lat_cycle1", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_cycle2", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send(48'h8000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h2, 32'h4000_0000, F_NONE);
        send(48'h7FFF_FFC0_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h3, 32'h4000_0000, F_INX);
        send(48'h4000_0040_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h4, 32'h3F80_0000, F_INX);
        send(48'h8000_0000_0000, 1'b1, 10'd254, 1'b0, 1'b0, 1'b0, 4'h5, 32'hFF80_0000,
             F_OVF | F_INX);
        send(48'h4000_0000_0000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, 4'h6, 32'h7F00_0000, F_NONE);
        send(48'h0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 4'h7, 32'h7FC0_0000, F_INV);
        send(48'h4000_0000_0000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 4'h8, unf_res, unf_flags);
        send(48'h6000_0000_0000, 1'b1, 10'd128, 1'b0, 1'b0, 1'b0, 4'h9, 32'hC040_0000, F_NONE);
        send(48'h0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b1, 4'hA, 32'h7FC0_0000, F_NONE);
        send(48'h4000_0000_0000, 1'b1, 10'd127, 1'b0, 1'b1, 1'b0, 4'hB, 32'hFF80_0000, F_NONE);
        send(48'h4000_0000_0000, 1'b1, 10'd127, 1'b0, 1'b0, 1'b1, 4'hC, 32'h8000_0000, F_NONE);
        // exp_sum = -200: far below the denormal range, rounds away to zero
        send(48'h4000_0000_0000, 1'b0, 10'h338, 1'b0, 1'b0, 1'b0, 4'hD, 32'h0000_0000,
             F_UNF | F_INX);
        drain();

        // Backpressure: two accepted, third refused, then ordered release
        out_ready = 1'b0;
        send(48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h1, 32'h3F80_0000, F_NONE);
        send(48'h8000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h2, 32'h4000_0000, F_NONE);
        drive(48'h6000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h3);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_hold_a", 64'({out_valid, result, out_tag}), 64'({1'b1, 32'h3F80_0000, 4'h1}));
        @(negedge clk);
        check("bp_hold_b", 64'({in_ready, result, out_tag}), 64'({1'b0, 32'h3F80_0000, 4'h1}));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back({32'h3FC0_0000, F_NONE, 4'h3});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with two entries in flight
        out_ready = 1'b0;
        send(48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h5, 32'h3F80_0000, F_NONE);
        send(48'h8000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'h6, 32'h4000_0000, F_NONE);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 64'({out_valid, result, flags, out_tag}), 64'(0));
        exp_q.delete();
        #6;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("post_rst_no_stale", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        @(posedge clk);
        #1;

        // Pipeline still works after the reset
        send(48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 4'hE, 32'h3F80_0000, F_NONE);
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
